// File: rtl/clkmux_cram_writer_pkg.sv
// Shared types and constants for the clock-mux CRAM writer: FSM states,
// 2x2 array geometry and default pulse lengths.
package clkmux_cram_writer_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_CLR    = 3'd1,
      ST_SETUP  = 3'd2,
      ST_STROBE = 3'd3,
      ST_HOLD   = 3'd4,
      ST_DONE   = 3'd5
   } state_e;

   localparam int ROWS        = 2;
   localparam int COLS        = 2;
   localparam int CNT_W       = 4;
   localparam int CFG_W       = 8;
   localparam int CLR_CYC_DEF = 4;
   localparam int WL_CYC_DEF  = 3;

   // Bit-line image for one row: {right col1, right col0, left col1, left col0}.
   function automatic logic [2*COLS-1:0] row_bits(input logic [CFG_W-1:0] cbits,
                                                 input logic row);
      return row ? {cbits[7:6], cbits[3:2]} : {cbits[5:4], cbits[1:0]};
   endfunction

endpackage

// File: rtl/clkmux_cram_pulse_cnt.sv
// Loadable down-counter with terminal-count flag; times the clear and
// word-line pulse durations.
module clkmux_cram_pulse_cnt
   import clkmux_cram_writer_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   input  logic             dec,
   output logic             tc
);

   logic [CNT_W-1:0] count;

   always_ff @(posedge clk) begin
      if (rst) begin
         count <= '0;
      end else if (load) begin
         count <= load_val;
      end else if (dec && (count != '0)) begin
         count <= count - 1'b1;
      end
   end

   assign tc = (count == '0);

endmodule

// File: rtl/clkmux_cram_writer.sv
// Programs the left/right 2x2 CRAM cells of a clock mux: clear, then per row
// drive bit-lines and strobe the word-line, then release the output gates.
// Handshake: cfg_data is taken on a rising edge where cfg_valid && cfg_ready;
// cfg_ready is high only in IDLE, so offers made while busy are ignored.
module clkmux_cram_writer
   import clkmux_cram_writer_pkg::*;
#(
   parameter int CLR_CYC = CLR_CYC_DEF,
   parameter int WL_CYC  = WL_CYC_DEF
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                cfg_valid,
   input  logic [CFG_W-1:0]    cfg_data,
   output logic                cfg_ready,
   output logic                busy,
   output logic                done,
   output logic                prog,
   output logic [2*COLS-1:0]   bl,
   output logic                bl_oe,
   output logic [ROWS-1:0]     wl_l,
   output logic [ROWS-1:0]     wl_r,
   output logic [ROWS-1:0]     reset_l,
   output logic [ROWS-1:0]     reset_r,
   output logic [ROWS-1:0]     pgate_l,
   output logic [ROWS-1:0]     pgate_r,
   output logic [ROWS-1:0]     vdd_cntl_l,
   output logic [ROWS-1:0]     vdd_cntl_r,
   output logic [2:0]          state_dbg
);

   localparam logic [CNT_W-1:0] CLR_LOAD = CNT_W'(CLR_CYC - 1);
   localparam logic [CNT_W-1:0] WL_LOAD  = CNT_W'(WL_CYC - 1);

   state_e           state, state_n;
   logic [CFG_W-1:0] cfg_q;
   logic             row_q;
   logic             capture, row_adv;
   logic             cnt_load, cnt_dec, cnt_tc;
   logic [CNT_W-1:0] cnt_val;

   clkmux_cram_pulse_cnt u_cnt (
      .clk      (clk),
      .rst      (rst),
      .load     (cnt_load),
      .load_val (cnt_val),
      .dec      (cnt_dec),
      .tc       (cnt_tc)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_IDLE;
         cfg_q <= '0;
         row_q <= 1'b0;
      end else begin
         state <= state_n;
         if (capture) begin
            cfg_q <= cfg_data;
            row_q <= 1'b0;
         end else if (row_adv) begin
            row_q <= 1'b1;
         end
      end
   end

   // Counter is loaded with N-1 on entry so a state lasts exactly N cycles.
   always_comb begin
      state_n  = state;
      capture  = 1'b0;
      row_adv  = 1'b0;
      cnt_load = 1'b0;
      cnt_dec  = 1'b0;
      cnt_val  = CLR_LOAD;
      case (state)
         ST_IDLE: begin
            if (cfg_valid) begin
               capture  = 1'b1;
               cnt_load = 1'b1;
               state_n  = ST_CLR;
            end
         end
         ST_CLR: begin
            if (cnt_tc) state_n = ST_SETUP;
            else        cnt_dec = 1'b1;
         end
         ST_SETUP: begin
            cnt_load = 1'b1;
            cnt_val  = WL_LOAD;
            state_n  = ST_STROBE;
         end
         ST_STROBE: begin
            if (cnt_tc) state_n = ST_HOLD;
            else        cnt_dec = 1'b1;
         end
         ST_HOLD: begin
            if (!row_q) begin
               row_adv = 1'b1;
               state_n = ST_SETUP;
            end else begin
               state_n = ST_DONE;
            end
         end
         ST_DONE: state_n = ST_IDLE;
         default: state_n = ST_IDLE;
      endcase
   end

   logic drive_bl;
   logic [ROWS-1:0] wl_row;

   always_comb begin
      drive_bl = (state == ST_SETUP) || (state == ST_STROBE) || (state == ST_HOLD);
      wl_row   = row_q ? 2'b10 : 2'b01;
   end

   assign cfg_ready  = (state == ST_IDLE);
   assign busy       = (state != ST_IDLE);
   assign prog       = busy;
   assign done       = (state == ST_DONE);
   assign bl_oe      = drive_bl;
   assign bl         = drive_bl ? row_bits(cfg_q, row_q) : '0;
   assign wl_l       = (state == ST_STROBE) ? wl_row : '0;
   assign wl_r       = (state == ST_STROBE) ? wl_row : '0;
   assign reset_l    = (state == ST_CLR) ? '1 : '0;
   assign reset_r    = (state == ST_CLR) ? '1 : '0;
   // Output gates open whenever the cells hold a stable image.
   assign pgate_l    = ((state == ST_IDLE) || (state == ST_DONE)) ? '1 : '0;
   assign pgate_r    = pgate_l;
   assign vdd_cntl_l = '0;
   assign vdd_cntl_r = '0;
   assign state_dbg  = state;

endmodule

// File: tb/tb_clkmux_cram_writer.sv
// Randomized bench for clkmux_cram_writer: two instances (default timing and
// CLR_CYC=1/WL_CYC=1) checked every cycle against a timeline reference model.
module tb_clkmux_cram_writer;

   typedef struct packed {
      logic       ready, busy, done, prog, bl_oe;
      logic [3:0] bl;
      logic [1:0] wl_l, wl_r, rs_l, rs_r, pg_l, pg_r, vd_l, vd_r;
   } obs_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       cfg_valid = 1'b0;
   logic [7:0] cfg_data = 8'h00;
   bit         chk_en = 1'b0;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   logic       rdy_a, bsy_a, dn_a, prg_a, oe_a, rdy_b, bsy_b, dn_b, prg_b, oe_b;
   logic [3:0] bl_a, bl_b;
   logic [1:0] wll_a, wlr_a, rsl_a, rsr_a, pgl_a, pgr_a, vdl_a, vdr_a;
   logic [1:0] wll_b, wlr_b, rsl_b, rsr_b, pgl_b, pgr_b, vdl_b, vdr_b;
   logic [2:0] st_a, st_b;

   clkmux_cram_writer u_dut (
      .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_data(cfg_data),
      .cfg_ready(rdy_a), .busy(bsy_a), .done(dn_a), .prog(prg_a),
      .bl(bl_a), .bl_oe(oe_a), .wl_l(wll_a), .wl_r(wlr_a),
      .reset_l(rsl_a), .reset_r(rsr_a), .pgate_l(pgl_a), .pgate_r(pgr_a),
      .vdd_cntl_l(vdl_a), .vdd_cntl_r(vdr_a), .state_dbg(st_a)
   );

   clkmux_cram_writer #(.CLR_CYC(1), .WL_CYC(1)) u_fast (
      .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_data(cfg_data),
      .cfg_ready(rdy_b), .busy(bsy_b), .done(dn_b), .prog(prg_b),
      .bl(bl_b), .bl_oe(oe_b), .wl_l(wll_b), .wl_r(wlr_b),
      .reset_l(rsl_b), .reset_r(rsr_b), .pgate_l(pgl_b), .pgate_r(pgr_b),
      .vdd_cntl_l(vdl_b), .vdd_cntl_r(vdr_b), .state_dbg(st_b)
   );

   obs_t obs [2];
   always_comb begin
      obs[0] = {rdy_a, bsy_a, dn_a, prg_a, oe_a, bl_a, wll_a, wlr_a,
                rsl_a, rsr_a, pgl_a, pgr_a, vdl_a, vdr_a};
      obs[1] = {rdy_b, bsy_b, dn_b, prg_b, oe_b, bl_b, wll_b, wlr_b,
                rsl_b, rsr_b, pgl_b, pgr_b, vdl_b, vdr_b};
   end

   function automatic int clr_of(int i); return (i == 0) ? 4 : 1; endfunction
   function automatic int wl_of(int i);  return (i == 0) ? 3 : 1; endfunction
   function automatic int lat_of(int i); return clr_of(i) + 2 * (wl_of(i) + 2) + 1; endfunction

   // Reference model: k = cycles since the accepting edge (1 = first busy cycle).
   bit         busy_m [2];
   int         k_m    [2];
   logic [7:0] data_m [2];

   always @(posedge clk) begin
      for (int i = 0; i < 2; i++) begin
         if (rst) begin
            busy_m[i] = 1'b0;
            k_m[i]    = 0;
            data_m[i] = 8'h00;
         end else if (busy_m[i]) begin
            if (k_m[i] == lat_of(i)) busy_m[i] = 1'b0;
            else                     k_m[i]++;
         end else if (cfg_valid) begin
            busy_m[i] = 1'b1;
            k_m[i]    = 1;
            data_m[i] = cfg_data;
         end
      end
   end

   function automatic obs_t model_out(bit b, int k, logic [7:0] d, int c, int w);
      obs_t e;
      int   j, row, p;
      e = '0;
      e.ready = 1'b1;
      e.pg_l  = 2'b11;
      e.pg_r  = 2'b11;
      if (b) begin
         e.ready = 1'b0;
         e.busy  = 1'b1;
         e.prog  = 1'b1;
         e.pg_l  = 2'b00;
         e.pg_r  = 2'b00;
         if (k <= c) begin
            e.rs_l = 2'b11;
            e.rs_r = 2'b11;
         end else if (k == c + 2 * (w + 2) + 1) begin
            e.done = 1'b1;
            e.pg_l = 2'b11;
            e.pg_r = 2'b11;
         end else begin
            j   = k - c - 1;
            row = j / (w + 2);
            p   = j % (w + 2);
            e.bl_oe = 1'b1;
            e.bl    = {d[4 + 2*row + 1], d[4 + 2*row], d[2*row + 1], d[2*row]};
            if (p >= 1 && p <= w) begin
               e.wl_l[row] = 1'b1;
               e.wl_r[row] = 1'b1;
            end
         end
      end
      return e;
   endfunction

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         for (int i = 0; i < 2; i++) begin
            obs_t e, o;
            string s;
            o = obs[i];
            e = model_out(busy_m[i], k_m[i], data_m[i], clr_of(i), wl_of(i));
            s = (i == 0) ? "dflt" : "fast";
            check({s, ".ctrl"},  {27'd0, o.ready, o.busy, o.done, o.prog, o.bl_oe},
                                 {27'd0, e.ready, e.busy, e.done, e.prog, e.bl_oe});
            check({s, ".bl"},    {28'd0, o.bl}, {28'd0, e.bl});
            check({s, ".wl"},    {28'd0, o.wl_l, o.wl_r}, {28'd0, e.wl_l, e.wl_r});
            check({s, ".reset"}, {28'd0, o.rs_l, o.rs_r}, {28'd0, e.rs_l, e.rs_r});
            check({s, ".pgate"}, {28'd0, o.pg_l, o.pg_r}, {28'd0, e.pg_l, e.pg_r});
            check({s, ".vdd"},   {28'd0, o.vd_l, o.vd_r}, 32'd0);
            check({s, ".inv"},
                  {29'd0, (&o.wl_l) | (&o.wl_r),
                   (|{o.wl_l, o.wl_r}) & (|{o.rs_l, o.rs_r}),
                   ((|{o.wl_l, o.wl_r}) & ~o.bl_oe) | (~o.bl_oe & (|o.bl))},
                  32'd0);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic offer(input logic [7:0] d);
      cfg_valid = 1'b1;
      cfg_data  = d;
      tick();
      cfg_valid = 1'b0;
      cfg_data  = $urandom_range(0, 255);
   endtask

   task automatic wait_idle();
      int n = 0;
      while (busy_m[0] || busy_m[1]) begin
         tick();
         if (++n > 200) begin
            check("wait_idle_timeout", 32'd0, 32'd1);
            break;
         end
      end
   endtask

   initial begin
      rst = 1'b1;
      tick();
      chk_en = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      tick();

      // Single word with data changing after acceptance.
      offer(8'hA5);
      wait_idle();
      tick();

      // Back-to-back all-zero then all-ones images.
      offer(8'h00);
      wait_idle();
      offer(8'hFF);
      wait_idle();
      tick();

      // cfg_valid held continuously with changing data.
      cfg_valid = 1'b1;
      for (int c = 0; c < 60; c++) begin
         cfg_data = $urandom_range(0, 255);
         tick();
      end
      cfg_valid = 1'b0;
      wait_idle();

      // Reset during row-1 strobe of the default instance.
      offer(8'h3C);
      begin
         int n = 0;
         while (!(busy_m[0] && k_m[0] == 12) && n < 100) begin
            tick();
            n++;
         end
         check("reach_row1_strobe", {31'd0, busy_m[0] && k_m[0] == 12}, 32'd1);
      end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      tick();
      tick();

      // Random traffic with occasional resets.
      for (int c = 0; c < 800; c++) begin
         cfg_valid = ($urandom_range(0, 3) != 0);
         cfg_data  = $urandom_range(0, 255);
         rst       = ($urandom_range(0, 99) == 0);
         tick();
      end
      rst       = 1'b0;
      cfg_valid = 1'b0;
      wait_idle();
      tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
